rns_to_int_mrc: RTL and testbench
=================================

// Module: rns_to_int_mrc
// PURPOSE
//  Reverse converter: packed 4-channel RNS word -> 32-bit binary integer, by sequential mixed-radix conversion (MRC).
//  Sits at the output of the RNS datapath (e.g. after the RNS FIR) and is the inverse of convertor_int_to_rns.
//  Valid/ready on both sides. One conversion in flight; fixed 6-cycle compute latency.
// PARAMETERS
//  M1          233  modulus of lane 1, residue bits [7:0]
//  M2          239  modulus of lane 2, residue bits [15:8]
//  M3          241  modulus of lane 3, residue bits [23:16]
//  M4          251  modulus of lane 4, residue bits [31:24]
//  SIGNED_OUT  0    1: map X > (M-1)/2 to X-M (two's complement); 0: plain unsigned X in [0,M-1]
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   in_rns holds a word to convert
//  in_ready   out  1   block can accept (state IDLE)
//  in_rns     in   32  {r4,r3,r2,r1}, each 8 bits
//  out_valid  out  1   out_data/out_err valid; held until accepted
//  out_ready  in   1   downstream accepts the result
//  out_data   out  32  converted integer
//  out_err    out  1   some residue >= its modulus; out_data forced to 0
// BEHAVIOUR
//  Constants: M = M1*M2*M3*M4 = 3,368,562,317 (< 2^32). Pairwise modular inverses inv(Mi mod Mj) come from an
//   elaboration-time constant function. Moduli must be pairwise coprime and < 256; no runtime check.
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, internal digit/residue regs cleared.
//  FSM: IDLE -> MRC (3 cycles, step counter 0..2) -> ACC (3 cycles, counter 0..2) -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready, capture residues, compute err flag (ri >= Mi for any i), go to MRC.
//  MRC step k (k=1..3): a_k = r_k; for every j>k: r_j <= ((r_j - a_k + Mj) mod Mj) * inv(Mk mod Mj) mod Mj.
//   Products 8x8 -> 16 bits, reduced mod Mj. After step 3: a4 = r4. All digits a_i lie in [0,Mi-1].
//  ACC (Horner, one multiply-add per cycle): acc=a4; acc=a3+M3*acc; acc=a2+M2*acc; X=a1+M1*acc.
//   Intermediates are <= M-1 and fit in 32 bits unsigned; no wrap.
//  Latency: accept on edge 0; out_valid=1 after edge 6; out_data is stable while out_valid=1.
//  DONE: out_valid=1, in_ready=0. On out_valid&&out_ready, out_valid drops and state returns to IDLE next edge.
//   The next input can be accepted one cycle later. Throughput: 1 result per >= 8 cycles.
//  Output map: err=1 -> out_data=0, out_err=1. Otherwise SIGNED_OUT=0 -> X.
//   SIGNED_OUT=1 -> X if X <= 1,684,281,158, else X-M (32-bit two's complement).
//  in_valid while busy (MRC/ACC/DONE): ignored; the word is not captured.
//  reset mid-conversion: conversion is aborted with no output; reset values apply on the next edge.
//  out_ready while out_valid=0: ignored.
// TESTING
//  {0,0,0,0} -> out_data=0, out_err=0, out_valid exactly 6 edges after accept.
//  {247,36,44,68} (1000) -> 1000. {46,54,156,229} (12345) -> 12345.
//  {250,240,238,232} (M-1): SIGNED_OUT=0 -> 3,368,562,316; SIGNED_OUT=1 -> 32'hFFFF_FFFF (-1).
//  r1=240 (>=233) -> out_err=1, out_data=0. Then a legal {1,1,1,1} -> 1, out_err=0.
//  out_ready low for 5 cycles in DONE -> out_valid/out_data held; in_valid pulses during MRC/ACC/DONE are not captured.
//  reset at MRC step 2 -> out_valid stays 0. Next input {247,36,44,68} converts to 1000 normally.
//  Random: 1000 integers in [0,M-1] through a reference int->RNS model -> exact round-trip, back-to-back valid.

Source files
------------

// File: rtl/rns_to_int_mrc.sv
// Reverse RNS converter: packed 4-lane residue word to a 32-bit integer using
// sequential mixed-radix conversion followed by a Horner accumulation.
module rns_to_int_mrc #(
   parameter int M1         = 233,
   parameter int M2         = 239,
   parameter int M3         = 241,
   parameter int M4         = 251,
   parameter bit SIGNED_OUT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rns,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_err
);

   function automatic int mod_inv(input int a, input int m);
      int r;
      r = 0;
      for (int x = 1; x < m; x++) begin
         if (r == 0 && ((a * x) % m) == 1) r = x;
      end
      return r;
   endfunction

   localparam logic [7:0]  INV12  = 8'(mod_inv(M1 % M2, M2));
   localparam logic [7:0]  INV13  = 8'(mod_inv(M1 % M3, M3));
   localparam logic [7:0]  INV14  = 8'(mod_inv(M1 % M4, M4));
   localparam logic [7:0]  INV23  = 8'(mod_inv(M2 % M3, M3));
   localparam logic [7:0]  INV24  = 8'(mod_inv(M2 % M4, M4));
   localparam logic [7:0]  INV34  = 8'(mod_inv(M3 % M4, M4));
   localparam logic [31:0] M_ALL  = 32'(longint'(M1) * longint'(M2) * longint'(M3) * longint'(M4));
   localparam logic [31:0] M_HALF = (M_ALL - 32'd1) >> 1;

   // (x - a) mod m; a is pre-reduced so the sum never underflows
   function automatic logic [7:0] sub_mod(input logic [7:0] x, input logic [7:0] a, input int m);
      logic [9:0] mm;
      logic [9:0] t;
      mm = 10'(m);
      t  = 10'(x) + mm - (10'(a) % mm);
      return 8'(t % mm);
   endfunction

   function automatic logic [7:0] mul_mod(input logic [7:0] x, input logic [7:0] k, input int m);
      logic [15:0] p;
      p = 16'(x) * 16'(k);
      return 8'(p % 16'(m));
   endfunction

   function automatic logic [31:0] out_map(input logic [31:0] x, input logic e);
      logic [31:0] y;
      if (e)
         y = 32'd0;
      else if (SIGNED_OUT && (x > M_HALF))
         y = x - M_ALL;
      else
         y = x;
      return y;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MRC  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [1:0]  step;
   logic [1:0]  step_next;
   logic [7:0]  r1;
   logic [7:0]  r2;
   logic [7:0]  r3;
   logic [7:0]  r4;
   logic        err;
   logic        err_in;
   logic [31:0] acc;

   assign err_in = (in_rns[7:0]   >= 8'(M1)) || (in_rns[15:8]  >= 8'(M2)) ||
                   (in_rns[23:16] >= 8'(M3)) || (in_rns[31:24] >= 8'(M4));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         step  <= 2'd0;
      end else begin
         state <= state_next;
         step  <= step_next;
      end
   end

   always_comb begin
      state_next = state;
      step_next  = step;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = MRC;
               step_next  = 2'd0;
            end
         end
         MRC: begin
            if (step == 2'd2) begin
               state_next = ACC;
               step_next  = 2'd0;
            end else begin
               step_next = step + 2'd1;
            end
         end
         ACC: begin
            if (step == 2'd2) begin
               state_next = DONE;
               step_next  = 2'd0;
            end else begin
               step_next = step + 2'd1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // After MRC the residue registers hold the mixed-radix digits a1..a4
   always_ff @(posedge clk) begin
      if (reset) begin
         r1       <= 8'd0;
         r2       <= 8'd0;
         r3       <= 8'd0;
         r4       <= 8'd0;
         err      <= 1'b0;
         acc      <= 32'd0;
         out_data <= 32'd0;
         out_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r1  <= in_rns[7:0];
                  r2  <= in_rns[15:8];
                  r3  <= in_rns[23:16];
                  r4  <= in_rns[31:24];
                  err <= err_in;
               end
            end
            MRC: begin
               case (step)
                  2'd0: begin
                     r2 <= mul_mod(sub_mod(r2, r1, M2), INV12, M2);
                     r3 <= mul_mod(sub_mod(r3, r1, M3), INV13, M3);
                     r4 <= mul_mod(sub_mod(r4, r1, M4), INV14, M4);
                  end
                  2'd1: begin
                     r3 <= mul_mod(sub_mod(r3, r2, M3), INV23, M3);
                     r4 <= mul_mod(sub_mod(r4, r2, M4), INV24, M4);
                  end
                  2'd2: r4 <= mul_mod(sub_mod(r4, r3, M4), INV34, M4);
                  default: ;
               endcase
            end
            ACC: begin
               case (step)
                  2'd0: acc <= 32'(r3) + 32'(M3) * 32'(r4);
                  2'd1: acc <= 32'(r2) + 32'(M2) * acc;
                  2'd2: begin
                     out_data <= out_map(32'(r1) + 32'(M1) * acc, err);
                     out_err  <= err;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rns_to_int_mrc.sv
// Bench for rns_to_int_mrc: directed vector table, multi-cycle corner sequences
// and a random round-trip, all checked through an expected-result queue.
module tb_rns_to_int_mrc;

   localparam longint M_ALL  = 64'd3368562317;
   localparam longint M_HALF = 64'd1684281158;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rns;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;
   logic        s_in_ready;
   logic        s_out_valid;
   logic [31:0] s_out_data;
   logic        s_out_err;

   typedef struct {
      logic [31:0] data;
      logic [31:0] sdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] rns;
      logic [31:0] data;
      logic [31:0] sdata;
      logic        err;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[5];
   int   checks;
   int   passes;

   rns_to_int_mrc #(.SIGNED_OUT(1'b0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_rns(in_rns),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
   );

   rns_to_int_mrc #(.SIGNED_OUT(1'b1)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_rns(in_rns),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_err(s_out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   function automatic logic [31:0] to_rns(input longint x);
      return {8'(x % 251), 8'(x % 241), 8'(x % 239), 8'(x % 233)};
   endfunction

   task automatic push_exp(input logic [31:0] d, input logic [31:0] sd, input logic e);
      exp_t x;
      x.data  = d;
      x.sdata = sd;
      x.err   = e;
      exp_q.push_back(x);
   endtask

   task automatic monitor();
      exp_t x;
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_out: out_data=%0h with no result pending, required none", out_data);
            end else begin
               x = exp_q.pop_front();
               check("out_data", out_data, x.data);
               check("out_err", 32'(out_err), 32'(x.err));
               check("s_out_valid", 32'(s_out_valid), 32'd1);
               check("s_out_data", s_out_data, x.sdata);
            end
         end
      end
   endtask

   task automatic send(input logic [31:0] rns, input bit keep);
      int n;
      in_rns   = rns;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic count_idle_valid(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
   endtask

   initial begin
      int   n;
      int   seen;
      longint x;

      checks = 0;
      passes = 0;
      vecs[0] = '{rns: {8'd247, 8'd36, 8'd44, 8'd68},    data: 32'd1000,       sdata: 32'd1000,     err: 1'b0};
      vecs[1] = '{rns: {8'd46, 8'd54, 8'd156, 8'd229},   data: 32'd12345,      sdata: 32'd12345,    err: 1'b0};
      vecs[2] = '{rns: {8'd250, 8'd240, 8'd238, 8'd232}, data: 32'd3368562316, sdata: 32'hFFFF_FFFF, err: 1'b0};
      vecs[3] = '{rns: {8'd1, 8'd1, 8'd1, 8'd240},       data: 32'd0,          sdata: 32'd0,        err: 1'b1};
      vecs[4] = '{rns: {8'd1, 8'd1, 8'd1, 8'd1},         data: 32'd1,          sdata: 32'd1,        err: 1'b0};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_rns    = 32'd0;
      out_ready = 1'b1;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_s_in_ready", 32'(s_in_ready), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      // zero word and accept-to-valid latency
      push_exp(32'd0, 32'd0, 1'b0);
      send(32'd0, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'd6);
      wait_drain(20);

      for (int i = 0; i < 5; i++) begin
         push_exp(vecs[i].data, vecs[i].sdata, vecs[i].err);
         send(vecs[i].rns, 1'b0);
         wait_drain(40);
      end

      // backpressure with busy-time input pulses
      out_ready = 1'b0;
      push_exp(32'd12345, 32'd12345, 1'b0);
      send(vecs[1].rns, 1'b0);
      check("busy_in_ready", 32'(in_ready), 32'd0);
      in_rns = vecs[4].rns;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", out_data, 32'd12345);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_drain(10);
      count_idle_valid(14, seen);
      check("no_extra_out", 32'(seen), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // reset while the MRC steps are running
      send(vecs[0].rns, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      count_idle_valid(12, seen);
      check("abort_no_out", 32'(seen), 32'd0);
      push_exp(32'd1000, 32'd1000, 1'b0);
      send(vecs[0].rns, 1'b0);
      wait_drain(40);

      // random round trip, valid held high back to back
      for (int i = 0; i < 1000; i++) begin
         x = longint'($urandom) % M_ALL;
         push_exp(32'(x), (x > M_HALF) ? 32'(x - M_ALL) : 32'(x), 1'b0);
         send(to_rns(x), 1'b1);
      end
      in_valid = 1'b0;
      wait_drain(100);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
